// File: rtl/obuf2axi_writeback.sv
// Output-side line writer: collects PIX-wide result beats into a ping-pong
// buffer and streams the line back as pixel-major AXI beats (w*coGroup+cog).
// Ports:
//   I_clk, I_rst          clock, async active-high reset
//   I_ap_start            layer start, rising edge is a synchronous clear
//   I_owidth, I_coGroup   line width in pixels, channel groups per pixel
//   I_result(_dv)         result beat in, O_result_rdy = write half free
//   O_feature(_dv)        output beat, held until I_feature_rdy
//   O_line_done           pulse after the last beat of a line handshakes
//   O_err                 sticky: result beat offered while not ready
module obuf2axi_writeback #(
   parameter int unsigned AXIWIDTH   = 128,
   parameter int unsigned LITEWIDTH  = 32,
   parameter int unsigned PIX        = 8,
   parameter int unsigned W_WIDTH    = 10,
   parameter int unsigned DEPTHWIDTH = 9,
   parameter int unsigned BANK_DEPTH = 512
) (
   input  logic                    I_clk,
   input  logic                    I_rst,
   input  logic                    I_ap_start,
   input  logic [LITEWIDTH-1:0]    I_owidth,
   input  logic [DEPTHWIDTH-1:0]   I_coGroup,
   input  logic [AXIWIDTH*PIX-1:0] I_result,
   input  logic                    I_result_dv,
   output logic                    O_result_rdy,
   output logic [AXIWIDTH-1:0]     O_feature,
   output logic                    O_feature_dv,
   input  logic                    I_feature_rdy,
   output logic                    O_line_done,
   output logic                    O_err
);
   localparam int unsigned PIXW = $clog2(PIX);
   localparam int unsigned AW   = $clog2(BANK_DEPTH);
   localparam int unsigned PW   = W_WIDTH + DEPTHWIDTH;
   localparam int unsigned RW   = W_WIDTH + PIXW;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   logic [AXIWIDTH-1:0] mem [2][PIX][BANK_DEPTH];

   state_t                state;
   logic                  ap_start_q;
   logic [1:0]            full;
   logic                  wsel;
   logic                  rsel;
   logic [DEPTHWIDTH-1:0] cog;
   logic [W_WIDTH-1:0]    wog;
   logic [DEPTHWIDTH-1:0] rcog;
   logic [RW-1:0]         rw;
   logic [AXIWIDTH-1:0]   sk_data;
   logic                  sk_dv;

   logic                  start;
   logic                  accept;
   logic                  wr_last;
   logic                  rd_last;
   logic                  pop;
   logic                  issue;
   logic                  rd_done;
   logic                  wsel_nxt;
   logic [1:0]            full_nxt;
   logic [LITEWIDTH-1:0]  wog_last;
   logic [AW-1:0]         waddr;
   logic [AW-1:0]         raddr;
   logic [PIXW-1:0]       rbank;
   logic [AXIWIDTH-1:0]   rdata;

   // Handshakes, addresses and next full/wsel (sync clear wins over everything)
   always_comb begin
      start    = I_ap_start && !ap_start_q;
      accept   = I_result_dv && O_result_rdy && !start;
      wog_last = ((I_owidth + LITEWIDTH'(PIX - 1)) >> PIXW) - LITEWIDTH'(1);
      wr_last  = (LITEWIDTH'(wog) == wog_last) && (cog == I_coGroup - DEPTHWIDTH'(1));
      waddr    = AW'(PW'(wog) * PW'(I_coGroup) + PW'(cog));
      rbank    = rw[PIXW-1:0];
      raddr    = AW'(PW'(rw[RW-1:PIXW]) * PW'(I_coGroup) + PW'(rcog));
      rdata    = mem[rsel][rbank][raddr];
      rd_last  = (LITEWIDTH'(rw) == I_owidth - LITEWIDTH'(1)) &&
                 (rcog == I_coGroup - DEPTHWIDTH'(1));
      pop      = O_feature_dv && I_feature_rdy;
      // A read lands in the skid at the same edge it is issued, so space is
      // "tail empty, or the head leaves this cycle".
      issue    = (state == RUN) && (!sk_dv || pop);
      rd_done  = (state == FLUSH) && pop && !sk_dv;
      full_nxt = full;
      wsel_nxt = wsel;
      if (accept && wr_last) begin
         full_nxt[wsel] = 1'b1;
         wsel_nxt       = !wsel;
      end
      if (rd_done) full_nxt[rsel] = 1'b0;
      if (start) begin
         full_nxt = 2'b00;
         wsel_nxt = 1'b0;
      end
   end

   // Line buffer: all PIX lanes of a beat written in parallel, one bank each
   always_ff @(posedge I_clk) begin
      if (accept) begin
         for (int p = 0; p < PIX; p++)
            mem[wsel][PIXW'(p)][waddr] <= I_result[p*AXIWIDTH +: AXIWIDTH];
      end
   end

   // Write counters, two-entry output skid and read FSM
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         state        <= IDLE;
         ap_start_q   <= 1'b0;
         full         <= 2'b00;
         wsel         <= 1'b0;
         rsel         <= 1'b0;
         cog          <= '0;
         wog          <= '0;
         rcog         <= '0;
         rw           <= '0;
         sk_data      <= '0;
         sk_dv        <= 1'b0;
         O_result_rdy <= 1'b1;
         O_feature    <= '0;
         O_feature_dv <= 1'b0;
         O_line_done  <= 1'b0;
         O_err        <= 1'b0;
      end else begin
         ap_start_q   <= I_ap_start;
         full         <= full_nxt;
         wsel         <= wsel_nxt;
         O_result_rdy <= !full_nxt[wsel_nxt];
         O_line_done  <= rd_done && !start;
         if (I_result_dv && !O_result_rdy) O_err <= 1'b1;
         if (start) begin
            state        <= IDLE;
            rsel         <= 1'b0;
            cog          <= '0;
            wog          <= '0;
            rcog         <= '0;
            rw           <= '0;
            sk_data      <= '0;
            sk_dv        <= 1'b0;
            O_feature    <= '0;
            O_feature_dv <= 1'b0;
         end else begin
            if (accept) begin
               if (cog == I_coGroup - DEPTHWIDTH'(1)) begin
                  cog <= '0;
                  wog <= wr_last ? '0 : wog + W_WIDTH'(1);
               end else begin
                  cog <= cog + DEPTHWIDTH'(1);
               end
            end
            // Head register is the output; tail only fills while head is held
            if (!O_feature_dv || pop) begin
               if (sk_dv) begin
                  O_feature    <= sk_data;
                  O_feature_dv <= 1'b1;
                  sk_dv        <= issue;
                  if (issue) sk_data <= rdata;
               end else begin
                  O_feature_dv <= issue;
                  if (issue) O_feature <= rdata;
               end
            end else if (issue) begin
               sk_data <= rdata;
               sk_dv   <= 1'b1;
            end
            case (state)
               IDLE: begin
                  rw   <= '0;
                  rcog <= '0;
                  if (full[rsel]) state <= RUN;
               end
               RUN: begin
                  if (issue) begin
                     if (rd_last) state <= FLUSH;
                     if (rcog == I_coGroup - DEPTHWIDTH'(1)) begin
                        rcog <= '0;
                        rw   <= rw + RW'(1);
                     end else begin
                        rcog <= rcog + DEPTHWIDTH'(1);
                     end
                  end
               end
               FLUSH: begin
                  if (rd_done) begin
                     rsel  <= !rsel;
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_obuf2axi_writeback.sv
// Self-checking bench for obuf2axi_writeback: table of line configurations,
// ping-pong / clear / reset sequences, and randomized back-to-back lines,
// all checked against a queue-based model of the pixel-major output order.
module tb_obuf2axi_writeback;
   localparam int unsigned AXIWIDTH   = 128;
   localparam int unsigned LITEWIDTH  = 32;
   localparam int unsigned PIX        = 8;
   localparam int unsigned W_WIDTH    = 10;
   localparam int unsigned DEPTHWIDTH = 9;
   localparam int unsigned BANK_DEPTH = 512;

   logic                    I_clk = 1'b0;
   logic                    I_rst = 1'b1;
   logic                    I_ap_start = 1'b0;
   logic [LITEWIDTH-1:0]    I_owidth = 16;
   logic [DEPTHWIDTH-1:0]   I_coGroup = 2;
   logic [AXIWIDTH*PIX-1:0] I_result = '0;
   logic                    I_result_dv = 1'b0;
   logic                    O_result_rdy;
   logic [AXIWIDTH-1:0]     O_feature;
   logic                    O_feature_dv;
   logic                    I_feature_rdy = 1'b1;
   logic                    O_line_done;
   logic                    O_err;

   obuf2axi_writeback #(
      .AXIWIDTH(AXIWIDTH), .LITEWIDTH(LITEWIDTH), .PIX(PIX),
      .W_WIDTH(W_WIDTH), .DEPTHWIDTH(DEPTHWIDTH), .BANK_DEPTH(BANK_DEPTH)
   ) dut (
      .I_clk(I_clk), .I_rst(I_rst), .I_ap_start(I_ap_start),
      .I_owidth(I_owidth), .I_coGroup(I_coGroup),
      .I_result(I_result), .I_result_dv(I_result_dv), .O_result_rdy(O_result_rdy),
      .O_feature(O_feature), .O_feature_dv(O_feature_dv), .I_feature_rdy(I_feature_rdy),
      .O_line_done(O_line_done), .O_err(O_err)
   );

   always #5 I_clk = ~I_clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [AXIWIDTH-1:0] exp_q[$];
   int                  len_q[$];

   logic                mon_en = 1'b0;
   int                  rdy_mode = 0;
   int                  pat_idx = 0;
   int                  beats_seen = 0;
   int                  done_cnt = 0;
   logic                done_due = 1'b0;
   logic                stall_prev = 1'b0;
   logic [AXIWIDTH-1:0] data_prev = '0;

   task automatic chk(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic chk_data(input string name, input logic [AXIWIDTH-1:0] got,
                           input logic [AXIWIDTH-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Lane content identifies line, pixel group, channel group and lane
   function automatic logic [AXIWIDTH-1:0] lane_val(input int unsigned seed, input int unsigned wg,
                                                    input int unsigned c, input int unsigned p);
      return {seed, wg, c, p};
   endfunction

   // Reference: pixel w of channel group c came in as lane w%PIX of beat (w/PIX, c)
   task automatic model_line(input int unsigned seed, input int ow, input int cg);
      for (int w = 0; w < ow; w++)
         for (int c = 0; c < cg; c++)
            exp_q.push_back(lane_val(seed, w / PIX, c, w % PIX));
      len_q.push_back(ow * cg);
   endtask

   // Output monitor: drives ready, scores handshakes, checks hold and line_done
   always @(negedge I_clk) begin
      #1;
      if (O_line_done) done_cnt++;
      if (mon_en) begin
         if (done_due || O_line_done) chk("line_done", int'(O_line_done), int'(done_due));
         if (stall_prev) begin
            chk("stall_dv", int'(O_feature_dv), 1);
            chk_data("stall_data", O_feature, data_prev);
         end
      end
      done_due = 1'b0;
      case (rdy_mode)
         0:       I_feature_rdy = 1'b1;
         1:       I_feature_rdy = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
         2:       I_feature_rdy = 1'b0;
         default: I_feature_rdy = 1'($urandom_range(0, 1));
      endcase
      pat_idx++;
      stall_prev = mon_en && O_feature_dv && !I_feature_rdy;
      data_prev  = O_feature;
      if (mon_en && O_feature_dv && I_feature_rdy) begin
         beats_seen++;
         if (exp_q.size() == 0) chk("extra_beat", 1, 0);
         else chk_data("beat", O_feature, exp_q.pop_front());
         if (len_q.size() > 0) begin
            len_q[0] = len_q[0] - 1;
            if (len_q[0] == 0) begin
               void'(len_q.pop_front());
               done_due = 1'b1;
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge right after the last acceptance
   task automatic push_line(input int unsigned seed, input int ow, input int cg, input bit gaps);
      int nw;
      int guard;
      nw = (ow + PIX - 1) / PIX;
      for (int wg = 0; wg < nw; wg++)
         for (int c = 0; c < cg; c++) begin
            if (gaps && $urandom_range(0, 3) == 0) @(negedge I_clk);
            guard = 0;
            while (!O_result_rdy && guard < 3000) begin
               @(negedge I_clk);
               guard++;
            end
            if (!O_result_rdy) begin
               chk("result_rdy_timeout", 0, 1);
               return;
            end
            for (int p = 0; p < PIX; p++)
               I_result[p*AXIWIDTH +: AXIWIDTH] = lane_val(seed, wg, c, p);
            I_result_dv = 1'b1;
            @(negedge I_clk);
            I_result_dv = 1'b0;
         end
   endtask

   task automatic wait_drain(input int lines);
      int guard;
      guard = 0;
      while ((exp_q.size() != 0 || done_cnt < lines) && guard < 5000) begin
         @(negedge I_clk);
         guard++;
      end
      repeat (3) @(negedge I_clk);
      chk("drain_left", exp_q.size(), 0);
      chk("line_done_count", done_cnt, lines);
      chk("rdy_after_drain", int'(O_result_rdy), 1);
   endtask

   task automatic wait_beats(input int n);
      int guard;
      guard = 0;
      while (beats_seen < n && guard < 2000) begin
         @(negedge I_clk);
         guard++;
      end
      chk("mid_line_reached", int'(beats_seen >= n), 1);
   endtask

   typedef struct {
      int ow;
      int cg;
      int mode;
      int exp_beats;
      int exp_lat;
   } vec_t;

   vec_t vecs[7];

   task automatic run_vec(input vec_t v, input string tag);
      int unsigned seed;
      int lat;
      seed = $urandom | 32'h1;
      rdy_mode   = v.mode;
      I_owidth   = LITEWIDTH'(v.ow);
      I_coGroup  = DEPTHWIDTH'(v.cg);
      done_cnt   = 0;
      beats_seen = 0;
      model_line(seed, v.ow, v.cg);
      push_line(seed, v.ow, v.cg, 1'b0);
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
         if (O_feature_dv) begin
            lat = k;
            break;
         end
         @(negedge I_clk);
      end
      chk({tag, "_first_dv_latency"}, lat, v.exp_lat);
      wait_drain(1);
      chk({tag, "_beat_count"}, beats_seen, v.exp_beats);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int unsigned s1;
      int unsigned s2;
      int ow;
      int cg;

      vecs[0] = '{16, 2, 0, 32, 3};
      vecs[1] = '{10, 1, 0, 10, 3};
      vecs[2] = '{16, 2, 1, 32, 3};
      vecs[3] = '{ 1, 1, 0,  1, 3};
      vecs[4] = '{ 9, 3, 1, 27, 3};
      vecs[5] = '{24, 1, 3, 24, 3};
      vecs[6] = '{ 8, 4, 3, 32, 3};

      // Reset values
      repeat (2) @(negedge I_clk);
      chk("rst_result_rdy", int'(O_result_rdy), 1);
      chk_data("rst_feature", O_feature, '0);
      chk("rst_feature_dv", int'(O_feature_dv), 0);
      chk("rst_line_done", int'(O_line_done), 0);
      chk("rst_err", int'(O_err), 0);
      I_rst = 1'b0;
      @(negedge I_clk);
      mon_en = 1'b1;
      @(negedge I_clk);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Ping-pong: two lines fill both halves while output is stalled
      rdy_mode  = 2;
      I_owidth  = 16;
      I_coGroup = 2;
      done_cnt  = 0;
      s1 = $urandom | 32'h1;
      s2 = $urandom | 32'h1;
      model_line(s1, 16, 2);
      push_line(s1, 16, 2, 1'b0);
      chk("pp_rdy_after_line1", int'(O_result_rdy), 1);
      model_line(s2, 16, 2);
      push_line(s2, 16, 2, 1'b0);
      chk("pp_rdy_after_line2", int'(O_result_rdy), 0);
      chk("pp_err_before", int'(O_err), 0);
      I_result    = '1;
      I_result_dv = 1'b1;
      @(negedge I_clk);
      I_result_dv = 1'b0;
      chk("pp_err_set", int'(O_err), 1);
      chk("pp_rdy_still_low", int'(O_result_rdy), 0);
      repeat (6) @(negedge I_clk);
      rdy_mode = 0;
      wait_drain(2);

      // Sync clear in the middle of a line
      rdy_mode   = 1;
      done_cnt   = 0;
      beats_seen = 0;
      s1 = $urandom | 32'h1;
      model_line(s1, 16, 2);
      push_line(s1, 16, 2, 1'b0);
      wait_beats(5);
      mon_en     = 1'b0;
      I_ap_start = 1'b1;
      @(negedge I_clk);
      chk("clr_feature_dv", int'(O_feature_dv), 0);
      chk("clr_result_rdy", int'(O_result_rdy), 1);
      chk("clr_err_kept", int'(O_err), 1);
      I_ap_start = 1'b0;
      exp_q.delete();
      len_q.delete();
      repeat (4) @(negedge I_clk);
      chk("clr_stays_idle", int'(O_feature_dv), 0);
      mon_en = 1'b1;
      @(negedge I_clk);
      run_vec(vecs[0], "after_clear");

      // Async reset in the middle of a line
      rdy_mode   = 1;
      done_cnt   = 0;
      beats_seen = 0;
      s1 = $urandom | 32'h1;
      model_line(s1, 16, 2);
      push_line(s1, 16, 2, 1'b0);
      wait_beats(3);
      mon_en = 1'b0;
      #2;
      I_rst = 1'b1;
      #1;
      chk("arst_feature_dv", int'(O_feature_dv), 0);
      chk_data("arst_feature", O_feature, '0);
      chk("arst_result_rdy", int'(O_result_rdy), 1);
      chk("arst_line_done", int'(O_line_done), 0);
      chk("arst_err", int'(O_err), 0);
      @(negedge I_clk);
      I_rst = 1'b0;
      exp_q.delete();
      len_q.delete();
      @(negedge I_clk);
      mon_en = 1'b1;
      @(negedge I_clk);
      run_vec(vecs[1], "after_reset");

      // Random batches: three lines back-to-back per configuration
      for (int b = 0; b < 4; b++) begin
         ow = $urandom_range(1, 40);
         cg = $urandom_range(1, 4);
         I_owidth  = LITEWIDTH'(ow);
         I_coGroup = DEPTHWIDTH'(cg);
         rdy_mode  = 3;
         done_cnt  = 0;
         for (int l = 0; l < 3; l++) begin
            s1 = $urandom | 32'h1;
            model_line(s1, ow, cg);
            push_line(s1, ow, cg, 1'b1);
         end
         wait_drain(3);
      end
      chk("final_err_clear", int'(O_err), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
